seq_divider: RTL

- Shared unsigned integer divider: the responder end of the dividend/divisor/start/busy/ready/result interface that the measurement blocks (speed, average speed) drive.
- Radix-2 restoring shift-subtract, one quotient bit per clock, WIDTH cycles per operation.
- Level handshake: the client holds start until it sees ready.
- Sits beside the measurement blocks in the bike-computer core. The top level muxes client requests onto its single port.

---
 rtl/div_pkg.sv | 23 ++
 rtl/seq_divider_if.sv | 51 +++++
 rtl/div_step.sv | 34 +++
 rtl/seq_divider.sv | 139 +++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider and its clients.
//   DIV_WIDTH     : default operand / quotient / remainder width. Clients use
//                   this value to size their dividend/divisor buses.
//   S_IDLE/RUN/DONE : 2-bit state encodings.
//   div_state_e   : enumerated FSM state type built on those encodings.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } div_state_e;

endpackage : div_pkg

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/response bundle between a measurement client and the shared divider.
//   start       : client -> divider, level request held until ready is seen
//   dividend    : client -> divider, numerator
//   divisor     : client -> divider, denominator
//   result      : divider -> client, quotient
//   remainder   : divider -> client, remainder
//   busy        : divider -> client, high while iterating
//   ready       : divider -> client, high while result is valid and start held
//   div_by_zero : divider -> client, divisor was zero for the current result
// Modports: master = client side, slave = divider side.
// -----------------------------------------------------------------------------
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             ready;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  result,
        input  remainder,
        input  busy,
        input  ready,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output result,
        output remainder,
        output busy,
        output ready,
        output div_by_zero
    );

endinterface : seq_divider_if

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step.
//   rem_i      : current partial remainder (always < d_i when d_i != 0)
//   q_msb_i    : next dividend bit shifted into the remainder
//   d_i        : divisor
//   rem_next_o : partial remainder after the trial subtraction
//   q_bit_o    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted remainder can need WIDTH+1 bits, so compare and subtract at
    // that width; the restored value always fits back into WIDTH bits.
    always_comb begin
        shifted    = {rem_i, q_msb_i};
        diff       = shifted - {1'b0, d_i};
        q_bit_o    = (shifted >= {1'b0, d_i});
        rem_next_o = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Shared unsigned radix-2 restoring divider, one quotient bit per clock,
// WIDTH iterations per operation, level start/ready handshake.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high; clears state and all outputs
//   bus : seq_divider_if.slave (start, dividend, divisor in;
//         result, remainder, busy, ready, div_by_zero out)
// All outputs are registered. Operands are captured only when a request is
// accepted in IDLE; later changes on the inputs have no effect.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    div_state_e       state_q,     state_d;
    logic [WIDTH-1:0] q_q,         q_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] d_q,         d_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q,      busy_d;
    logic             ready_q,     ready_d;
    logic             dbz_q,       dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] q_shifted;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .q_msb_i    (q_q[WIDTH-1]),
        .d_i        (d_q),
        .rem_next_o (step_rem),
        .q_bit_o    (step_bit)
    );

    // The quotient register doubles as the dividend shift register: dividend
    // bits leave at the top while quotient bits enter at the bottom.
    assign q_shifted = {q_q[WIDTH-2:0], step_bit};

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        rem_d       = rem_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    dbz_d   = (bus.divisor == '0);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                q_d   = q_shifted;
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                // Last iteration: publish the final step directly so the
                // result appears on the same edge busy falls.
                if (cnt_q == CNT_W'(1)) begin
                    busy_d      = 1'b0;
                    ready_d     = 1'b1;
                    result_d    = q_shifted;
                    remainder_d = step_rem;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                // Stay here while the client still holds start so a held
                // request cannot launch a second operation.
                if (!bus.start) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            rem_q       <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.ready       = ready_q;
    assign bus.div_by_zero = dbz_q;

endmodule : seq_divider
